// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and consumer-side signals of the UART receive FIFO
interface uart_rx_fifo_if #(parameter int AW = 4) ();
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_perr;
    logic        rx_rdy_clr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        empty;
    logic        full;
    logic [AW:0] level;
    logic        overflow;
    logic        ovf_clr;
    modport slave (
        input  rx_data, rx_rdy, rx_perr, rd_en, ovf_clr,
        output rx_rdy_clr, rd_data, rd_perr, empty, full, level, overflow
    );
    modport master (
        output rx_data, rx_rdy, rx_perr, rd_en, ovf_clr,
        input  rx_rdy_clr, rd_data, rd_perr, empty, full, level, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO behind a UART receiver; define UART_RX_FIFO_PERR_DROP_EN to discard parity-error bytes
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
`ifdef UART_RX_FIFO_PERR_DROP_EN
    localparam int W = 8;
`else
    localparam int W = 9;
`endif
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          empty_q, full_q, overflow_q, clr_q;
    logic          cap, keep, pop, wr, drop;
    logic [W-1:0]  entry;
    // capture/pop qualification; a pop in the same cycle frees the slot for a write at full
    always_comb begin
        cap     = bus.rx_rdy & ~clr_q;
`ifdef UART_RX_FIFO_PERR_DROP_EN
        keep    = ~bus.rx_perr;
        entry   = bus.rx_data;
`else
        keep    = 1'b1;
        entry   = {bus.rx_perr, bus.rx_data};
`endif
        pop     = bus.rd_en & ~empty_q;
        wr      = cap & keep & (~full_q | pop);
        drop    = cap & keep & full_q & ~pop;
        level_d = level_q + (AW+1)'(wr) - (AW+1)'(pop);
    end
    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= entry;
    end
    // pointers, occupancy, sticky overflow and the one-cycle receiver acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            clr_q      <= cap;
            wr_ptr_q   <= wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            level_q    <= level_d;
            empty_q    <= level_d == '0;
            full_q     <= level_d == (AW+1)'(DEPTH);
            overflow_q <= drop ? 1'b1 : bus.ovf_clr ? 1'b0 : overflow_q;
        end
    end
    assign bus.rd_data    = mem[rd_ptr_q][7:0];
`ifdef UART_RX_FIFO_PERR_DROP_EN
    assign bus.rd_perr    = 1'b0;
`else
    assign bus.rd_perr    = mem[rd_ptr_q][8];
`endif
    assign bus.rx_rdy_clr = clr_q;
    assign bus.level      = level_q;
    assign bus.empty      = empty_q;
    assign bus.full       = full_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of capture handshake, full/overflow, wrap, parity handling and async reset
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   b2b = 0;
    logic prev_clr = 1'b0;
    uart_rx_fifo_if #(.AW(4)) bus ();
    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    // count acknowledge pulses and flag any that run two cycles back to back
    always @(negedge clk) begin
        if (bus.rx_rdy_clr) pulses <= pulses + 1;
        if (bus.rx_rdy_clr && prev_clr) b2b <= b2b + 1;
        prev_clr <= bus.rx_rdy_clr;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    // receiver model: raise rdy, keep it up until the edge on which it sees rdy_clr
    task automatic send(input logic [7:0] d, input logic p, input logic pop, input logic oc);
        int n;
        @(negedge clk);
        bus.rx_data = d; bus.rx_perr = p; bus.rx_rdy = 1'b1; bus.rd_en = pop; bus.ovf_clr = oc;
        @(posedge clk); #1;
        bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        n = 0;
        while (!bus.rx_rdy_clr && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.rx_rdy_clr) chk("ack_timeout", 0, 1);
        @(posedge clk); #1;
        bus.rx_rdy = 1'b0;
    endtask
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk(tag, bus.rd_data, exp);
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
    endtask
    task automatic fill();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        int p0;
        bus.rx_data = '0; bus.rx_rdy = 1'b0; bus.rx_perr = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", bus.level, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_clr", bus.rx_rdy_clr, 0);
        rst = 1'b0;
        p0 = pulses;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("a5_pulses", pulses - p0, 1);
        chk("a5_level", bus.level, 1);
        chk("a5_perr", bus.rd_perr, 0);
        pop_chk("a5_data", 8'hA5);
        @(negedge clk);
        chk("a5_empty", bus.empty, 1);
        p0 = pulses;
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("perr_pulse", pulses - p0, 1);
        chk("perr_ovf", bus.overflow, 0);
`ifdef UART_RX_FIFO_PERR_DROP_EN
        chk("perr_level", bus.level, 0);
`else
        chk("perr_level", bus.level, 1);
        chk("perr_flag", bus.rd_perr, 1);
        pop_chk("perr_data", 8'h3C);
`endif
        fill();
        @(negedge clk);
        chk("fill_full", bus.full, 1);
        chk("fill_level", bus.level, 16);
        chk("fill_ovf", bus.overflow, 0);
        p0 = pulses;
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_pulse", pulses - p0, 1);
        chk("drop_ovf", bus.overflow, 1);
        chk("drop_level", bus.level, 16);
        for (int i = 0; i < 16; i++) pop_chk("drain", 8'(i));
        @(negedge clk);
        chk("drain_empty", bus.empty, 1);
        chk("drain_ovf_sticky", bus.overflow, 1);
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        chk("ovf_clr", bus.overflow, 0);
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
        chk("under_level", bus.level, 0);
        chk("under_empty", bus.empty, 1);
        fill();
        send(8'h55, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("simul_level", bus.level, 16);
        chk("simul_ovf", bus.overflow, 0);
        for (int i = 1; i < 16; i++) pop_chk("simul_order", 8'(i));
        pop_chk("simul_last", 8'h55);
        fill();
        send(8'hEE, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("set_wins", bus.overflow, 1);
        for (int i = 0; i < 16; i++) pop_chk("sw_drain", 8'(i));
        for (int i = 0; i < 20; i++) begin
            send(8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
            pop_chk("wrap", 8'h80 + 8'(i));
        end
        @(negedge clk);
        chk("wrap_empty", bus.empty, 1);
        for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.rx_data = 8'h46; bus.rx_rdy = 1'b1;
        @(posedge clk); #2;
        chk("pre_rst_level", bus.level, 7);
        chk("pre_rst_ovf", bus.overflow, 1);
        chk("pre_rst_clr", bus.rx_rdy_clr, 1);
        rst = 1'b1;
        bus.rx_rdy = 1'b0;
        #1;
        chk("async_level", bus.level, 0);
        chk("async_empty", bus.empty, 1);
        chk("async_full", bus.full, 0);
        chk("async_ovf", bus.overflow, 0);
        chk("async_clr", bus.rx_rdy_clr, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_level", bus.level, 0);
        send(8'h77, 1'b0, 1'b0, 1'b0);
        pop_chk("post_rst_data", 8'h77);
        @(negedge clk);
        chk("no_b2b", b2b, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
